// File: rtl/memory_arbiter.sv
`default_nettype none
//============================================================================
// Module      : memory_arbiter
// Description : Single-port RAM arbiter between the pipeline fetch (I) side
//               and the memory-stage (D) side. Exactly one RAM transaction is
//               in flight at a time; D requests win over fetches when both
//               are pending in IDLE. Produces one-cycle ihit/dhit pulses for
//               the hazard unit. A per-transaction watchdog aborts accesses
//               that never see ram_rdy and raises a sticky err flag.
// Ports       :
//   CLK, RST              clock (rising edge), async active-high reset
//   halt                  blocks new fetches; D requests still served
//   iREN, iaddr           fetch request / address (held until ihit)
//   ihit, iload           fetch done pulse / fetched word
//   dREN, dWEN            data read / write request (held until dhit)
//   daddr, dstore         data address / write data
//   dhit, dload           data done pulse / read word
//   ram_ren, ram_wen      RAM strobes, held until ram_rdy
//   ram_addr, ram_store   latched RAM address / write data
//   ram_load, ram_rdy     RAM read data / access-complete
//   err                   sticky timeout flag
// Revision    : 1.0 - initial release
//============================================================================
module memory_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255     // legal range 1..255 (8-bit watchdog)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              halt,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              ihit,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dhit,
    output logic [DATA_W-1:0] dload,
    output logic              ram_ren,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_store,
    input  logic [DATA_W-1:0] ram_load,
    input  logic              ram_rdy,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_IREQ = 3'd1,
        S_DREQ = 3'd2,
        S_IHIT = 3'd3,
        S_DHIT = 3'd4
    } state_t;

    localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT);

    state_t            r_state,     w_state_next;
    logic [7:0]        r_cnt,       w_cnt_next;
    logic              r_is_write,  w_is_write_next;
    logic              r_ram_ren,   w_ram_ren_next;
    logic              r_ram_wen,   w_ram_wen_next;
    logic [ADDR_W-1:0] r_ram_addr,  w_ram_addr_next;
    logic [DATA_W-1:0] r_ram_store, w_ram_store_next;
    logic              r_ihit,      w_ihit_next;
    logic              r_dhit,      w_dhit_next;
    logic [DATA_W-1:0] r_iload,     w_iload_next;
    logic [DATA_W-1:0] r_dload,     w_dload_next;
    logic              r_err,       w_err_next;

    logic [7:0]        w_cnt_inc;
    logic              w_expired;
    logic              w_dreq;

    // Counter holds the number of strobe cycles already completed; the
    // current strobe cycle is the last one allowed when the increment hits
    // TIMEOUT, so the strobe is high for exactly TIMEOUT cycles.
    assign w_cnt_inc = r_cnt + 8'd1;
    assign w_expired = (w_cnt_inc == c_TIMEOUT);
    assign w_dreq    = dREN | dWEN;

    //------------------------------------------------------------------------
    // Next-state and next-output logic. Every output is a register, so the
    // values computed here appear on the ports one cycle later.
    //------------------------------------------------------------------------
    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_is_write_next  = r_is_write;
        w_ram_ren_next   = 1'b0;
        w_ram_wen_next   = 1'b0;
        w_ram_addr_next  = r_ram_addr;
        w_ram_store_next = r_ram_store;
        w_ihit_next      = 1'b0;
        w_dhit_next      = 1'b0;
        w_iload_next     = r_iload;
        w_dload_next     = r_dload;
        w_err_next       = r_err;

        case (r_state)
            S_IDLE: begin
                if (w_dreq) begin
                    // A simultaneous read+write request is treated as a write.
                    w_state_next     = S_DREQ;
                    w_cnt_next       = 8'd0;
                    w_is_write_next  = dWEN;
                    w_ram_addr_next  = daddr;
                    w_ram_store_next = dstore;
                    w_ram_ren_next   = ~dWEN;
                    w_ram_wen_next   = dWEN;
                end else if (iREN && !halt) begin
                    w_state_next    = S_IREQ;
                    w_cnt_next      = 8'd0;
                    w_is_write_next = 1'b0;
                    w_ram_addr_next = iaddr;
                    w_ram_ren_next  = 1'b1;
                end
            end

            S_IREQ: begin
                if (ram_rdy) begin
                    // Data is captured even when the fetch was withdrawn; only
                    // the hit pulse is suppressed.
                    w_state_next = S_IHIT;
                    w_iload_next = ram_load;
                    w_ihit_next  = iREN;
                end else if (w_expired) begin
                    w_state_next = S_IDLE;
                    w_err_next   = 1'b1;
                end else begin
                    w_cnt_next     = w_cnt_inc;
                    w_ram_ren_next = 1'b1;
                end
            end

            S_DREQ: begin
                if (ram_rdy) begin
                    w_state_next = S_DHIT;
                    if (!r_is_write) begin
                        w_dload_next = ram_load;
                    end
                    w_dhit_next = w_dreq;
                end else if (w_expired) begin
                    w_state_next = S_IDLE;
                    w_err_next   = 1'b1;
                end else begin
                    w_cnt_next     = w_cnt_inc;
                    w_ram_ren_next = ~r_is_write;
                    w_ram_wen_next = r_is_write;
                end
            end

            S_IHIT,
            S_DHIT: begin
                w_state_next = S_IDLE;
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    //------------------------------------------------------------------------
    // State and output registers.
    //------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            r_is_write  <= 1'b0;
            r_ram_ren   <= 1'b0;
            r_ram_wen   <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_store <= '0;
            r_ihit      <= 1'b0;
            r_dhit      <= 1'b0;
            r_iload     <= '0;
            r_dload     <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_is_write  <= w_is_write_next;
            r_ram_ren   <= w_ram_ren_next;
            r_ram_wen   <= w_ram_wen_next;
            r_ram_addr  <= w_ram_addr_next;
            r_ram_store <= w_ram_store_next;
            r_ihit      <= w_ihit_next;
            r_dhit      <= w_dhit_next;
            r_iload     <= w_iload_next;
            r_dload     <= w_dload_next;
            r_err       <= w_err_next;
        end
    end

    assign ihit      = r_ihit;
    assign dhit      = r_dhit;
    assign iload     = r_iload;
    assign dload     = r_dload;
    assign ram_ren   = r_ram_ren;
    assign ram_wen   = r_ram_wen;
    assign ram_addr  = r_ram_addr;
    assign ram_store = r_ram_store;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
//============================================================================
// Module      : tb_memory_arbiter
// Description : Self-checking bench for memory_arbiter. The bench plays the
//               role of both requesters and the RAM (a sparse memory model
//               with a chosen per-transaction latency) and predicts strobe
//               length, hit pulses, loaded data and err from transaction-level
//               rules.
// Revision    : 1.0 - initial release
//============================================================================
module tb_memory_arbiter;

    localparam int TO = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic        halt;
    logic        iREN;
    logic [31:0] iaddr;
    logic        ihit;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dhit;
    logic [31:0] dload;
    logic        ram_ren;
    logic        ram_wen;
    logic [31:0] ram_addr;
    logic [31:0] ram_store;
    logic [31:0] ram_load;
    logic        ram_rdy;
    logic        err;

    memory_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST), .halt(halt),
        .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dhit(dhit), .dload(dload),
        .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_store(ram_store), .ram_load(ram_load), .ram_rdy(ram_rdy),
        .err(err)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state
    logic [31:0] mem [logic [31:0]];
    logic [31:0] exp_iload = '0;
    logic [31:0] exp_dload = '0;
    logic        exp_err   = 1'b0;

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'hA5A5_5A5A;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ihit"}, ihit, 0);
        check({tag, "_dhit"}, dhit, 0);
        check({tag, "_ren"}, ram_ren, 0);
        check({tag, "_wen"}, ram_wen, 0);
        check({tag, "_addr"}, ram_addr, 0);
        check({tag, "_store"}, ram_store, 0);
        check({tag, "_iload"}, iload, 0);
        check({tag, "_dload"}, dload, 0);
        check({tag, "_err"}, err, 0);
    endtask

    // One transaction started from IDLE in the current cycle. The RAM answers
    // on strobe cycle 'lat'; lat > TO means the RAM never answers in time.
    task automatic run_txn(input bit is_d, input bit is_w, input logic [31:0] addr,
                           input logic [31:0] wdata, input int lat, input bit withdraw);
        int          n_strobe;
        bit          exp_hit;
        logic [31:0] rdata;
        n_strobe = (lat <= TO) ? lat : TO;
        exp_hit  = (lat <= TO) && !withdraw;
        rdata    = mem_read(addr);
        if (is_d) begin
            daddr = addr; dstore = wdata; dWEN = is_w; dREN = !is_w;
        end else begin
            iaddr = addr; iREN = 1'b1;
        end
        for (int j = 1; j <= n_strobe; j++) begin
            tick();
            check("strobe_ren", ram_ren, {31'd0, is_d ? !is_w : 1'b1});
            check("strobe_wen", ram_wen, {31'd0, is_d & is_w});
            check("strobe_addr", ram_addr, addr);
            if (is_d && is_w) check("strobe_store", ram_store, wdata);
            check("no_hit_in_req", {31'd0, ihit | dhit}, 0);
            if (withdraw) begin iREN = 0; dREN = 0; dWEN = 0; end
            if (j == lat) begin
                ram_rdy  = 1'b1;
                ram_load = (is_d && is_w) ? $urandom : rdata;
            end
        end
        tick();
        ram_rdy = 1'b0;
        if (lat <= TO) begin
            if (!is_d) exp_iload = rdata;
            else if (!is_w) exp_dload = rdata;
            else mem[addr] = wdata;
            check("hit_ihit", ihit, {31'd0, !is_d && exp_hit});
            check("hit_dhit", dhit, {31'd0, is_d && exp_hit});
        end else begin
            exp_err = 1'b1;
            check("to_ihit", ihit, 0);
            check("to_dhit", dhit, 0);
        end
        check("post_ren", ram_ren, 0);
        check("post_wen", ram_wen, 0);
        check("iload", iload, exp_iload);
        check("dload", dload, exp_dload);
        check("err", err, exp_err);
        iREN = 0; dREN = 0; dWEN = 0;
        tick();
        check("idle_hits", {31'd0, ihit | dhit}, 0);
        check("idle_strobe", {31'd0, ram_ren | ram_wen}, 0);
    endtask

    initial begin
        RST = 1'b1; halt = 0; iREN = 0; iaddr = 0; dREN = 0; dWEN = 0;
        daddr = 0; dstore = 0; ram_load = 0; ram_rdy = 0;
        tick();
        tick();
        check_all_zero("reset");
        #3 RST = 1'b0;
        tick();

        // Fetch only, RAM answers on the 3rd strobe cycle
        mem[32'h40] = 32'hDEAD_BEEF;
        run_txn(0, 0, 32'h40, 0, 3, 0);
        check("fetch_iload", iload, 32'hDEAD_BEEF);

        // Simultaneous I and D: D first, ram_rdy held high throughout
        mem[32'h80] = 32'hCAFE_0080;
        iaddr = 32'h200; iREN = 1; daddr = 32'h80; dREN = 1;
        ram_rdy = 1; ram_load = mem_read(32'h80);
        tick();
        check("sim_c1_ren", ram_ren, 1);
        check("sim_c1_addr", ram_addr, 32'h80);
        check("sim_c1_hits", {31'd0, ihit | dhit}, 0);
        tick();
        exp_dload = 32'hCAFE_0080;
        check("sim_c2_dhit", dhit, 1);
        check("sim_c2_ihit", ihit, 0);
        check("sim_c2_dload", dload, exp_dload);
        dREN = 0; ram_load = mem_read(32'h200);
        tick();
        check("sim_c3_ren", ram_ren, 0);
        check("sim_c3_hits", {31'd0, ihit | dhit}, 0);
        tick();
        check("sim_c4_ren", ram_ren, 1);
        check("sim_c4_addr", ram_addr, 32'h200);
        tick();
        exp_iload = mem_read(32'h200);
        check("sim_c5_ihit", ihit, 1);
        check("sim_c5_dhit", dhit, 0);
        check("sim_c5_iload", iload, exp_iload);
        iREN = 0; ram_rdy = 0;
        tick();
        check("sim_c6_hits", {31'd0, ihit | dhit}, 0);

        // Write, then read it back
        run_txn(1, 1, 32'h100, 32'h1234, 2, 0);
        check("wr_dload_kept", dload, 32'hCAFE_0080);
        run_txn(1, 0, 32'h100, 0, 1, 0);
        check("rd_back", dload, 32'h1234);

        // Fetch withdrawn mid-access: no ihit, iload still updated
        mem[32'h44] = 32'h0BAD_F00D;
        run_txn(0, 0, 32'h44, 0, 2, 1);
        check("withdraw_iload", iload, 32'h0BAD_F00D);

        // RAM answers on the last permitted cycle, then a timeout
        run_txn(1, 0, 32'h80, 0, TO, 0);
        check("err_before_to", err, 0);
        run_txn(1, 0, 32'h84, 0, 10, 0);
        check("err_after_to", err, 1);
        run_txn(0, 0, 32'h40, 0, 1, 0);

        // halt blocks fetches, D still served
        halt = 1; iREN = 1; iaddr = 32'h48;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("halt_no_fetch", ram_ren, 0);
        end
        run_txn(1, 0, 32'h100, 0, 2, 0);
        halt = 0;

        // Randomized transactions
        for (int n = 0; n < 60; n++) begin
            bit          r_d;
            bit          r_w;
            logic [31:0] r_a;
            r_d = 1'($urandom_range(0, 1));
            r_w = r_d & 1'($urandom_range(0, 1));
            r_a = 32'($urandom_range(0, 15)) << 2;
            run_txn(r_d, r_w, r_a, $urandom, $urandom_range(1, TO + 1),
                    ($urandom_range(0, 7) == 0));
        end

        // Reset in the middle of a write strobe
        dWEN = 1; daddr = 32'h300; dstore = 32'h5555;
        tick();
        check("pre_rst_wen", ram_wen, 1);
        #2 RST = 1'b1;
        #1;
        check_all_zero("midrst");
        exp_iload = 0; exp_dload = 0; exp_err = 0;
        #2 RST = 1'b0;
        dWEN = 0; halt = 1; iREN = 1; iaddr = 32'h40;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("post_rst_no_fetch", ram_ren, 0);
            check("post_rst_no_ihit", ihit, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Safety net against a stuck run
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
